// File: rtl/key_debounce_array.sv
// key_debounce_array
//   N-channel key debouncer with press/release/auto-repeat event pulses.
//   Raw pins are synchronised and normalised so that pressed = 1. They are
//   sampled on a shared divided tick. A key's debounced level flips only
//   after STABLE_CNT consecutive disagreeing samples.
// Ports:
//   Clk_10khz   system clock
//   Rst_n       asynchronous active-low reset
//   Key_in      raw key pins (polarity set by ACTIVE_LOW)
//   Repeat_en   global auto-repeat enable (level)
//   Key_level   debounced level, 1 = pressed
//   Key_press   one-cycle pulse on debounced 0->1
//   Key_release one-cycle pulse on debounced 1->0
//   Key_repeat  one-cycle auto-repeat pulse
//   Any_press   OR of Key_press
module key_debounce_array #(
  parameter int N_KEYS       = 4,
  parameter int SAMPLE_DIV   = 100,
  parameter int STABLE_CNT   = 3,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic              Clk_10khz,
  input  logic              Rst_n,
  input  logic [N_KEYS-1:0] Key_in,
  input  logic              Repeat_en,
  output logic [N_KEYS-1:0] Key_level,
  output logic [N_KEYS-1:0] Key_press,
  output logic [N_KEYS-1:0] Key_release,
  output logic [N_KEYS-1:0] Key_repeat,
  output logic              Any_press
);

  localparam int TW   = $clog2(SAMPLE_DIV);
  localparam int DW   = $clog2(STABLE_CNT + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(STABLE_CNT - 1);
  localparam logic [RW-1:0] RD_LAST   = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RR_LAST   = RW'(REPEAT_RATE - 1);
  // Pin level of a released key; the first stage resets here so that the
  // normalised second stage starts out "released".
  localparam logic [N_KEYS-1:0] PIN_IDLE = (ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [1:0] {IDLE, DELAY, RPT} rpt_state_t;

  logic [N_KEYS-1:0] sync1, sync2;
  logic [TW-1:0]     tick_cnt;
  logic              tick;
  logic [DW-1:0]     db_cnt [N_KEYS];
  logic [RW-1:0]     rp_cnt [N_KEYS];
  rpt_state_t        state  [N_KEYS];
  logic [N_KEYS-1:0] flip;
  logic [N_KEYS-1:0] level_nxt;

  always_ff @(posedge Clk_10khz or negedge Rst_n) begin
    if (!Rst_n) begin
      sync1 <= PIN_IDLE;
      sync2 <= '0;
    end else begin
      sync1 <= Key_in;
      sync2 <= (ACTIVE_LOW != 0) ? ~sync1 : sync1;
    end
  end

  always_ff @(posedge Clk_10khz or negedge Rst_n) begin
    if (!Rst_n)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TW'(1);
  end

  assign tick = (tick_cnt == TICK_LAST);

  // Checking the pre-increment count against STABLE_CNT-1 is equivalent to
  // checking the incremented value against STABLE_CNT, without overflow.
  always_comb begin
    flip = '0;
    for (int unsigned i = 0; i < N_KEYS; i++)
      flip[i] = tick && (sync2[i] != Key_level[i]) && (db_cnt[i] == DB_LAST);
  end

  assign level_nxt = Key_level ^ flip;

  always_ff @(posedge Clk_10khz or negedge Rst_n) begin
    if (!Rst_n) begin
      Key_level   <= '0;
      Key_press   <= '0;
      Key_release <= '0;
      for (int unsigned i = 0; i < N_KEYS; i++) db_cnt[i] <= '0;
    end else begin
      Key_level   <= level_nxt;
      Key_press   <= flip & ~Key_level;
      Key_release <= flip & Key_level;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        if (tick) begin
          if (sync2[i] == Key_level[i] || flip[i]) db_cnt[i] <= '0;
          else                                     db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  // The hold test uses the next-cycle level so that a release on the same
  // tick as a due repeat suppresses the repeat pulse.
  always_ff @(posedge Clk_10khz or negedge Rst_n) begin
    if (!Rst_n) begin
      Key_repeat <= '0;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        state[i]  <= IDLE;
        rp_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        Key_repeat[i] <= 1'b0;
        case (state[i])
          IDLE: begin
            if (Key_press[i] && Repeat_en && level_nxt[i]) begin
              state[i]  <= DELAY;
              rp_cnt[i] <= '0;
            end
          end
          DELAY: begin
            if (!(level_nxt[i] && Repeat_en)) begin
              state[i] <= IDLE;
            end else if (tick) begin
              if (rp_cnt[i] == RD_LAST) begin
                Key_repeat[i] <= 1'b1;
                rp_cnt[i]     <= '0;
                state[i]      <= RPT;
              end else begin
                rp_cnt[i] <= rp_cnt[i] + RW'(1);
              end
            end
          end
          RPT: begin
            if (!(level_nxt[i] && Repeat_en)) begin
              state[i] <= IDLE;
            end else if (tick) begin
              if (rp_cnt[i] == RR_LAST) begin
                Key_repeat[i] <= 1'b1;
                rp_cnt[i]     <= '0;
              end else begin
                rp_cnt[i] <= rp_cnt[i] + RW'(1);
              end
            end
          end
          default: state[i] <= IDLE;
        endcase
      end
    end
  end

  assign Any_press = |Key_press;

endmodule

// File: tb/tb_key_debounce_array.sv
// Testbench for key_debounce_array: directed stimulus pushes expected events
// (pulse vector plus an arrival window) to a queue; a negedge monitor pops and
// checks every pulse the DUT produces, and flags any unexpected pulse.
module tb_key_debounce_array;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_in = 4'hF;
  logic       repeat_en = 1'b0;
  logic [3:0] key_level, key_press, key_release, key_repeat;
  logic       any_press;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_evt = 0;
  int b;

  typedef struct {
    logic [11:0] vec;   // {repeat, release, press}
    int          lo;
    int          hi;
    bit          rel;   // window relative to previous observed event
    int          base;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  logic [11:0] obs;
  int          ebase;

  key_debounce_array #(
    .N_KEYS(4), .SAMPLE_DIV(4), .STABLE_CNT(3),
    .REPEAT_DELAY(5), .REPEAT_RATE(2), .ACTIVE_LOW(1)
  ) dut (
    .Clk_10khz  (clk),
    .Rst_n      (rst_n),
    .Key_in     (key_in),
    .Repeat_en  (repeat_en),
    .Key_level  (key_level),
    .Key_press  (key_press),
    .Key_release(key_release),
    .Key_repeat (key_repeat),
    .Any_press  (any_press)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] x);
    total++;
    assert (o === x) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, x);
    end
  endtask

  task automatic chk_win(input string tag, input int d, input int lo, input int hi);
    total++;
    assert (d >= lo && d <= hi) else begin
      bad++;
      $error("FAIL %s observed_delay=%0d expected=%0d..%0d", tag, d, lo, hi);
    end
  endtask

  task automatic expect_evt(input logic [11:0] v, input int lo, input int hi,
                            input bit rel, input int base);
    exp_t t;
    t.vec = v; t.lo = lo; t.hi = hi; t.rel = rel; t.base = base;
    q.push_back(t);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    obs = {key_repeat, key_release, key_press};
    chk("any_press", {31'd0, any_press}, {31'd0, |key_press});
    if (obs != 12'd0) begin
      if (q.size() == 0) begin
        chk("unexpected_event", {20'd0, obs}, 32'd0);
      end else begin
        e = q.pop_front();
        ebase = e.rel ? last_evt : e.base;
        chk("event_vec", {20'd0, obs}, {20'd0, e.vec});
        chk_win("event_time", cyc - ebase, e.lo, e.hi);
      end
      last_evt = cyc;
    end
  end

  initial begin
    // 1: reset with idle-high pins, then 100 quiet cycles
    rst_n = 1'b0; key_in = 4'hF; repeat_en = 1'b0;
    step(3);
    chk("rst_level", {28'd0, key_level}, 32'd0);
    chk("rst_pulses", {20'd0, key_press, key_release, key_repeat}, 32'd0);
    rst_n = 1'b1;
    step(100);
    chk("idle_level", {28'd0, key_level}, 32'd0);

    // 2: clean press and release of key 0
    b = cyc;
    expect_evt({8'h00, 4'b0001}, 10, 14, 1'b0, b);
    key_in[0] = 1'b0;
    step(60);
    chk("s2_level_held", {28'd0, key_level}, 32'h1);
    b = cyc;
    expect_evt({4'h0, 4'b0001, 4'h0}, 10, 14, 1'b0, b);
    key_in[0] = 1'b1;
    step(30);
    chk("s2_level_rel", {28'd0, key_level}, 32'd0);
    chk("s2_queue", q.size(), 32'd0);

    // 3: bounce on key 1, toggling every 5 cycles
    for (int k = 0; k < 12; k++) begin
      key_in[1] = ~key_in[1];
      step(5);
    end
    step(30);
    chk("s3_level", {28'd0, key_level}, 32'd0);

    // 4: auto-repeat on key 2; release 120 cycles after press keeps the same
    // tick phase, so the release lands 4 cycles after the 13th repeat
    repeat_en = 1'b1;
    b = cyc;
    expect_evt({8'h00, 4'b0100}, 10, 14, 1'b0, b);
    expect_evt({4'b0100, 8'h00}, 20, 20, 1'b1, 0);
    for (int k = 0; k < 12; k++) expect_evt({4'b0100, 8'h00}, 8, 8, 1'b1, 0);
    expect_evt({4'h0, 4'b0100, 4'h0}, 4, 4, 1'b1, 0);
    key_in[2] = 1'b0;
    step(60);
    chk("s4_level_held", {28'd0, key_level}, 32'h4);
    step(60);
    key_in[2] = 1'b1;
    step(30);
    chk("s4_level_rel", {28'd0, key_level}, 32'd0);
    chk("s4_queue", q.size(), 32'd0);

    // 5: drop Repeat_en after the first repeat, re-enable while still held
    b = cyc;
    expect_evt({8'h00, 4'b0100}, 10, 14, 1'b0, b);
    expect_evt({4'b0100, 8'h00}, 20, 20, 1'b1, 0);
    expect_evt({4'h0, 4'b0100, 4'h0}, 100, 100, 1'b1, 0);
    key_in[2] = 1'b0;
    step(36);
    repeat_en = 1'b0;
    step(24);
    repeat_en = 1'b1;
    step(60);
    key_in[2] = 1'b1;
    step(30);
    chk("s5_queue", q.size(), 32'd0);

    // 6: keys 0 and 3 together, 1-cycle reset while held
    repeat_en = 1'b0;
    b = cyc;
    expect_evt({8'h00, 4'b1001}, 10, 14, 1'b0, b);
    key_in = 4'b0110;
    step(30);
    chk("s6_level", {28'd0, key_level}, 32'h9);
    rst_n = 1'b0;
    #1;
    chk("s6_rst_level", {28'd0, key_level}, 32'd0);
    chk("s6_rst_pulses", {20'd0, key_press, key_release, key_repeat}, 32'd0);
    step(1);
    rst_n = 1'b1;
    b = cyc;
    expect_evt({8'h00, 4'b1001}, 12, 16, 1'b0, b);
    step(30);
    chk("s6_level_again", {28'd0, key_level}, 32'h9);
    b = cyc;
    expect_evt({4'h0, 4'b1001, 4'h0}, 10, 14, 1'b0, b);
    key_in = 4'hF;
    step(30);
    chk("s6_level_rel", {28'd0, key_level}, 32'd0);
    chk("final_queue", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
